// File: rtl/if_prefetch_unit.sv
// Fetch front-end: credit-limited sequential IMEM requests, in-order prefetch queue, redirect flush/squash.
// Optional JAL predecode redirect when IF_JAL_PREDECODE_EN is defined.
module if_prefetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [31:0]     if_inst,
  output logic            if_pred_taken
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] CREDIT_LIMIT = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] fly_pc [DEPTH];
  logic [AW-1:0]   fly_wr, fly_rd;
  logic [CW-1:0]   outstanding, outstanding_next, discard;

  logic [XLEN-1:0] q_pc   [DEPTH];
  logic [31:0]     q_inst [DEPTH];
  logic [AW-1:0]   q_head, q_tail;
  logic [CW-1:0]   q_count;

  logic [CW:0]     credit_sum;
  logic            req_fire, rsp_keep, rsp_jal, push, pop;
  logic [XLEN-1:0] rsp_pc, jal_target;

  // Every issued request already owns a queue slot, so a kept response can always be pushed.
  assign credit_sum       = {1'b0, q_count} + {1'b0, outstanding};
  assign imem_req_valid   = !rst && !redirect_valid && (credit_sum < CREDIT_LIMIT);
  assign imem_req_addr    = fetch_pc;
  assign req_fire         = imem_req_valid && imem_req_ready;
  assign rsp_pc           = fly_pc[fly_rd];
  assign rsp_keep         = imem_rsp_valid && (discard == '0);
  assign push             = rsp_keep && !redirect_valid;
  assign pop              = if_valid && if_ready;
  assign outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

`ifdef IF_JAL_PREDECODE_EN
  logic [XLEN-1:0] j_imm;
  logic            q_pred [DEPTH];

  assign j_imm      = {{(XLEN-20){imem_rsp_data[31]}}, imem_rsp_data[19:12], imem_rsp_data[20],
                       imem_rsp_data[30:21], 1'b0};
  assign rsp_jal    = rsp_keep && (imem_rsp_data[6:0] == 7'b1101111);
  assign jal_target = (rsp_pc + j_imm) & WORD_MASK;

  always_ff @(posedge clk) begin
    if (push) q_pred[q_tail] <= rsp_jal;
  end

  assign if_pred_taken = if_valid ? q_pred[q_head] : 1'b0;
`else
  assign rsp_jal       = 1'b0;
  assign jal_target    = '0;
  assign if_pred_taken = 1'b0;
`endif

  // NOTE: storage arrays carry no reset; validity lives in the counters and the head outputs are
  // masked with if_valid, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (req_fire) fly_pc[fly_wr] <= fetch_pc;
    if (push) begin
      q_pc[q_tail]   <= rsp_pc;
      q_inst[q_tail] <= imem_rsp_data;
    end
  end

  // NOTE: all state updates use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      fly_wr      <= '0;
      fly_rd      <= '0;
      outstanding <= '0;
      discard     <= '0;
      q_head      <= '0;
      q_tail      <= '0;
      q_count     <= '0;
    end else begin
      if (req_fire)       fly_wr <= fly_wr + AW'(1);
      if (imem_rsp_valid) fly_rd <= fly_rd + AW'(1);
      outstanding <= outstanding_next;

      if (redirect_valid) begin
        // Everything still in flight after this cycle belongs to the abandoned path.
        fetch_pc <= redirect_pc & WORD_MASK;
        discard  <= outstanding_next;
        q_head   <= '0;
        q_tail   <= '0;
        q_count  <= '0;
      end else begin
        if (rsp_jal) begin
          fetch_pc <= jal_target;
          discard  <= outstanding_next;
        end else begin
          if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
          if (imem_rsp_valid && (discard != '0)) discard <= discard - CW'(1);
        end
        if (push) q_tail <= q_tail + AW'(1);
        if (pop)  q_head <= q_head + AW'(1);
        q_count <= q_count + CW'(push) - CW'(pop);
      end
    end
  end

  assign if_valid = (q_count != '0);
  assign if_pc    = if_valid ? q_pc[q_head]   : '0;
  assign if_inst  = if_valid ? q_inst[q_head] : '0;

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Bench for if_prefetch_unit: behavioural IMEM with configurable latency and ready pattern,
// expected fetch stream kept in a scoreboard queue and compared on every decode handshake.
module tb_if_prefetch_unit;

  localparam int XLEN = 32;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic [31:0] JAL_WORD = 32'h0200006F;  // jal x0, +32

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid, if_ready, if_pred_taken;
  logic [31:0] if_pc, if_inst;

  if_prefetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
    .if_pred_taken(if_pred_taken)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; int due; } rsp_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic pred; } exp_t;

  rsp_t        rsp_q[$];
  exp_t        exp_q[$];
  logic [31:0] req_log[$];
  int          req_cyc[$];
  int          deq_cyc[$];

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int lat = 1;

  logic        drv_rst = 1'b1;
  logic        drv_req_ready = 1'b1;
  logic        want_ready = 1'b0;
  logic        drv_redirect = 1'b0;
  logic [31:0] drv_redirect_pc = '0;
  bit          toggle_ready = 0, check_stable = 0, jal_mode = 0, redirect_on_jal = 0;
  logic        prev_stalled = 1'b0;
  logic [31:0] prev_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (jal_mode && a == 32'h8) return JAL_WORD;
    return {a[24:0], 7'b0010011};
  endfunction

  function automatic exp_t mk(input logic [31:0] pc, input logic pred);
    exp_t e;
    e.pc = pc; e.inst = mem_word(pc); e.pred = pred;
    return e;
  endfunction

  // One clock cycle: drive inputs after the falling edge, sample outputs 1 time unit later.
  task automatic tick();
    rsp_t r;
    exp_t e;
    @(negedge clk);
    cyc++;
    rst            = drv_rst;
    redirect_valid = drv_redirect;
    redirect_pc    = drv_redirect_pc;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (drv_rst) rsp_q.delete();
    else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      r = rsp_q.pop_front();
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = r.data;
      if (redirect_on_jal && r.addr == 32'h8) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
      end
    end
    imem_req_ready = toggle_ready ? cyc[0] : drv_req_ready;
    if_ready       = want_ready && (exp_q.size() > 0);
    #1;
    if (check_stable && prev_stalled && imem_req_valid) begin
      tests_run++;
      if (imem_req_addr !== prev_addr) begin
        tests_failed++;
        $display("FAIL addr_stable: got %h, expected %h", imem_req_addr, prev_addr);
      end
    end
    prev_stalled = imem_req_valid && !imem_req_ready;
    prev_addr    = imem_req_addr;
    if (imem_req_valid && imem_req_ready) begin
      r.addr = imem_req_addr; r.data = mem_word(imem_req_addr); r.due = cyc + lat;
      rsp_q.push_back(r);
      req_log.push_back(imem_req_addr);
      req_cyc.push_back(cyc);
    end
    if (if_valid && if_ready) begin
      e = exp_q.pop_front();
      tests_run++;
      if (if_pc !== e.pc || if_inst !== e.inst || if_pred_taken !== e.pred) begin
        tests_failed++;
        $display("FAIL dequeue: got pc=%h inst=%h pred=%b, expected pc=%h inst=%h pred=%b",
                 if_pc, if_inst, if_pred_taken, e.pc, e.inst, e.pred);
      end
      deq_cyc.push_back(cyc);
    end
  endtask

  task automatic wait_drain(input int budget, input string name);
    int k = 0;
    while (exp_q.size() > 0 && k < budget) begin
      tick();
      k++;
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL %s: %0d entries still expected after %0d cycles, expected 0", name, exp_q.size(), budget);
    end
  endtask

  // Leaves rst asserted for two cycles; the next tick is the first cycle out of reset.
  task automatic do_reset();
    exp_q.delete();
    want_ready = 1'b0;
    drv_redirect = 1'b0;
    drv_req_ready = 1'b1;
    drv_rst = 1'b1;
    tick();
    tick();
    drv_rst = 1'b0;
    req_log.delete();
    req_cyc.delete();
    deq_cyc.delete();
    prev_stalled = 1'b0;
  endtask

  task automatic test_reset();
    drv_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if ({imem_req_valid, if_valid, if_pred_taken} !== 3'b000 || if_pc !== '0 || if_inst !== '0) begin
        tests_failed++;
        $display("FAIL reset_outputs: got req_valid=%b if_valid=%b pc=%h inst=%h pred=%b, expected all 0",
                 imem_req_valid, if_valid, if_pc, if_inst, if_pred_taken);
      end
    end
  endtask

  task automatic test_sequential();
    int start;
    do_reset();
    start = cyc;
    lat = 1;
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(32'(i * 4), 1'b0));
    want_ready = 1'b1;
    wait_drain(40, "seq_drain");
    want_ready = 1'b0;
    tests_run++;
    if (req_log.size() == 0 || req_log[0] !== RESET_PC || req_cyc[0] != start + 1) begin
      tests_failed++;
      $display("FAIL seq_first_req: got addr=%h at cycle +%0d, expected %h at +1",
               req_log.size() > 0 ? req_log[0] : 32'hx, req_cyc.size() > 0 ? req_cyc[0] - start : -1, RESET_PC);
    end
    tests_run++;
    if (deq_cyc.size() < 8 || deq_cyc[7] - deq_cyc[0] != 7 || deq_cyc[0] - req_cyc[0] != 2) begin
      tests_failed++;
      $display("FAIL seq_rate: got %0d dequeues, span %0d, first latency %0d, expected 8, 7, 2", deq_cyc.size(),
               deq_cyc.size() >= 8 ? deq_cyc[7] - deq_cyc[0] : -1, deq_cyc.size() > 0 ? deq_cyc[0] - req_cyc[0] : -1);
    end
  endtask

  task automatic test_stall();
    do_reset();
    lat = 1;
    repeat (10) tick();
    tests_run++;
    if (req_log.size() != DEPTH) begin
      tests_failed++;
      $display("FAIL stall_req_count: got %0d, expected %0d", req_log.size(), DEPTH);
    end
    tests_run++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== mem_word(32'h0)) begin
      tests_failed++;
      $display("FAIL stall_head: got valid=%b pc=%h inst=%h, expected 1 %h %h", if_valid, if_pc, if_inst,
               32'h0, mem_word(32'h0));
    end
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(32'(i * 4), 1'b0));
    want_ready = 1'b1;
    wait_drain(60, "stall_drain");
    want_ready = 1'b0;
  endtask

  task automatic test_redirect();
    int k = 0;
    int idx;
    do_reset();
    lat = 3;
    exp_q.push_back(mk(32'h100, 1'b0));
    exp_q.push_back(mk(32'h104, 1'b0));
    exp_q.push_back(mk(32'h108, 1'b0));
    want_ready = 1'b1;
    while (rsp_q.size() < 2 && k < 10) begin
      tick();
      k++;
    end
    drv_redirect = 1'b1;
    drv_redirect_pc = 32'h100;
    tick();
    drv_redirect = 1'b0;
    tests_run++;
    if (imem_req_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL redirect_req_valid: got %b, expected 0", imem_req_valid);
    end
    wait_drain(40, "redirect_drain");
    tests_run++;
    if (req_log.size() < 3 || req_log[2] !== 32'h100) begin
      tests_failed++;
      $display("FAIL redirect_fetch: got %h, expected %h", req_log.size() > 2 ? req_log[2] : 32'hx, 32'h100);
    end
    want_ready = 1'b0;
    exp_q.push_back(mk(32'h100, 1'b0));
    exp_q.push_back(mk(32'h104, 1'b0));
    drv_redirect = 1'b1;
    drv_redirect_pc = 32'h103;
    tick();
    drv_redirect = 1'b0;
    idx = req_log.size();
    want_ready = 1'b1;
    wait_drain(40, "redirect_align_drain");
    want_ready = 1'b0;
    tests_run++;
    if (req_log.size() <= idx || req_log[idx] !== 32'h100) begin
      tests_failed++;
      $display("FAIL redirect_align: got %h, expected %h", req_log.size() > idx ? req_log[idx] : 32'hx, 32'h100);
    end
  endtask

  task automatic test_toggle();
    do_reset();
    lat = 3;
    toggle_ready = 1;
    check_stable = 1;
    for (int i = 0; i < 8; i++) exp_q.push_back(mk(32'(i * 4), 1'b0));
    want_ready = 1'b1;
    wait_drain(80, "toggle_drain");
    want_ready = 1'b0;
    toggle_ready = 0;
    check_stable = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    lat = 1;
    repeat (10) tick();
    tests_run++;
    if (if_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_full: got if_valid=%b, expected 1", if_valid);
    end
    drv_rst = 1'b1;
    tick();
    tick();
    tests_run++;
    if (if_valid !== 1'b0 || imem_req_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset: got if_valid=%b req_valid=%b, expected 0 0", if_valid, imem_req_valid);
    end
    drv_rst = 1'b0;
    req_log.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(mk(32'(i * 4), 1'b0));
    want_ready = 1'b1;
    wait_drain(30, "mid_drain");
    want_ready = 1'b0;
    tests_run++;
    if (req_log.size() == 0 || req_log[0] !== RESET_PC) begin
      tests_failed++;
      $display("FAIL mid_refetch: got %h, expected %h", req_log.size() > 0 ? req_log[0] : 32'hx, RESET_PC);
    end
  endtask

`ifdef IF_JAL_PREDECODE_EN
  task automatic test_jal_predecode();
    do_reset();
    lat = 1;
    jal_mode = 1;
    exp_q.push_back(mk(32'h0, 1'b0));
    exp_q.push_back(mk(32'h4, 1'b0));
    exp_q.push_back(mk(32'h8, 1'b1));
    exp_q.push_back(mk(32'h28, 1'b0));
    exp_q.push_back(mk(32'h2C, 1'b0));
    want_ready = 1'b1;
    wait_drain(40, "jal_drain");
    want_ready = 1'b0;
    jal_mode = 0;
  endtask

  task automatic test_jal_ex_wins();
    do_reset();
    lat = 1;
    jal_mode = 1;
    redirect_on_jal = 1;
    exp_q.push_back(mk(32'h0, 1'b0));
    exp_q.push_back(mk(32'h4, 1'b0));
    exp_q.push_back(mk(32'h200, 1'b0));
    exp_q.push_back(mk(32'h204, 1'b0));
    want_ready = 1'b1;
    wait_drain(40, "jal_ex_drain");
    want_ready = 1'b0;
    redirect_on_jal = 0;
    jal_mode = 0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    if_ready = 1'b0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_toggle();
    test_reset_mid();
`ifdef IF_JAL_PREDECODE_EN
    test_jal_predecode();
    test_jal_ex_wins();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
